// File: rtl/disp_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package disp_pkg;
    localparam logic [3:0] BLANK_CODE = 4'hF;
    localparam int         DIGITS     = 4;

    typedef logic [3:0] digit_t;
    typedef enum logic {SHOW, BLANK} scan_state_t;
endpackage

// File: rtl/scan_tick_gen.sv
// Purpose: free-running divider, one-cycle tick every DIV enabled cycles.
// Latency: tick asserted combinationally in the cycle the count reaches DIV-1.
// Backpressure: none; en low holds the count at zero.
module scan_tick_gen #(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int W = (DIV > 2) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;

    assign tick = en && (cnt == W'(DIV - 1));

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (!en || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/display_scan_ctrl.sv
// Purpose: 4-digit seven-segment scan scheduler, tear-free frames, dead-time blanking, LZ suppression; SCAN_BLINK_EN adds blink_mask.
// Latency: sel/num/frame_start registered, one cycle after the state change that produces them.
// Backpressure: none; loads outside the frame boundary wait in a single pending slot (last wins).
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 8
`ifdef SCAN_BLINK_EN
    ,
    parameter int BLINK_DIV    = 50000000
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] digits,
    input  logic        lz_en,
`ifdef SCAN_BLINK_EN
    input  logic [3:0]  blink_mask,
`endif
    output logic [1:0]  sel,
    output logic [3:0]  num,
    output logic        frame_start
);
    localparam int           BW         = (BLANK_CYCLES > 2) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [BW-1:0] BLANK_LAST = BW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    scan_state_t     state, next_state;
    logic [15:0]     active, pending, next_active;
    logic            pending_valid;
    logic [BW-1:0]   blank_cnt;
    logic            show_en, tick, advance, wrap;
    logic [1:0]      next_sel;
    logic [DIGITS-1:0] lz_hide, blink_hide;
    digit_t          d     [DIGITS];
    digit_t          shown [DIGITS];
    digit_t          num_next;

    // Refresh counter only runs while a digit is on; it sits at zero through dead time.
    assign show_en = (state == SHOW);

    scan_tick_gen #(.DIV(REFRESH_DIV)) u_refresh (
        .clk  (clk),
        .rst  (rst),
        .en   (show_en),
        .tick (tick)
    );

`ifdef SCAN_BLINK_EN
    logic blink_tick, blink_phase;

    scan_tick_gen #(.DIV(BLINK_DIV)) u_blink (
        .clk  (clk),
        .rst  (rst),
        .en   (1'b1),
        .tick (blink_tick)
    );

    always_ff @(posedge clk) begin
        if (rst)
            blink_phase <= 1'b0;
        else if (blink_tick)
            blink_phase <= ~blink_phase;
    end

    assign blink_hide = blink_phase ? blink_mask : '0;
`else
    assign blink_hide = '0;
`endif

    always_comb begin
        advance    = 1'b0;
        next_state = state;
        if (state == SHOW) begin
            if (tick) begin
                if (BLANK_CYCLES == 0)
                    advance = 1'b1;
                else
                    next_state = BLANK;
            end
        end else if (blank_cnt == BLANK_LAST) begin
            advance    = 1'b1;
            next_state = SHOW;
        end
    end

    assign wrap     = advance && (sel == 2'd3);
    assign next_sel = sel + {1'b0, advance};

    // The frame swap and the first digit of the new frame land on the same edge.
    always_comb begin
        next_active = active;
        if (wrap && (pending_valid || load))
            next_active = load ? digits : pending;
    end

    always_comb begin
        for (int i = 0; i < DIGITS; i++)
            d[i] = next_active[4*i +: 4];
    end

    assign lz_hide[3] = lz_en && (d[3] == 4'h0);
    assign lz_hide[2] = lz_hide[3] && (d[2] == 4'h0);
    assign lz_hide[1] = lz_hide[2] && (d[1] == 4'h0);
    assign lz_hide[0] = 1'b0;

    always_comb begin
        for (int i = 0; i < DIGITS; i++)
            shown[i] = (lz_hide[i] || blink_hide[i]) ? BLANK_CODE : d[i];
    end

    assign num_next = (next_state == BLANK) ? BLANK_CODE : shown[next_sel];

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= SHOW;
            sel           <= 2'd0;
            num           <= BLANK_CODE;
            frame_start   <= 1'b0;
            active        <= 16'h0;
            pending       <= 16'h0;
            pending_valid <= 1'b0;
            blank_cnt     <= '0;
        end else begin
            state       <= next_state;
            sel         <= next_sel;
            num         <= num_next;
            frame_start <= wrap;
            active      <= next_active;

            if (load && !wrap) begin
                pending       <= digits;
                pending_valid <= 1'b1;
            end else if (wrap) begin
                pending_valid <= 1'b0;
            end

            if ((state == BLANK) && !advance)
                blank_cnt <= blank_cnt + 1'b1;
            else
                blank_cnt <= '0;
        end
    end
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: REFRESH_DIV=4, BLANK_CYCLES=2 (and a BLANK_CYCLES=0 instance).
module tb_display_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] digits = 16'h0;
    logic        lz_en = 1'b0;
    logic [3:0]  blink_mask = 4'b0;
    logic [1:0]  sel, sel_nb;
    logic [3:0]  num, num_nb;
    logic        frame_start, fs_nb;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [1:0] cap_sel [24];
    logic [3:0] cap_num [24];
    logic       cap_fs  [24];
    logic       cap_fs_end;
    int         cap_cyc0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    display_scan_ctrl #(
        .REFRESH_DIV(4), .BLANK_CYCLES(2)
`ifdef SCAN_BLINK_EN
        , .BLINK_DIV(16)
`endif
    ) dut (
        .clk(clk), .rst(rst), .load(load), .digits(digits), .lz_en(lz_en),
`ifdef SCAN_BLINK_EN
        .blink_mask(blink_mask),
`endif
        .sel(sel), .num(num), .frame_start(frame_start)
    );

    display_scan_ctrl #(
        .REFRESH_DIV(4), .BLANK_CYCLES(0)
`ifdef SCAN_BLINK_EN
        , .BLINK_DIV(16)
`endif
    ) dut_nb (
        .clk(clk), .rst(rst), .load(load), .digits(digits), .lz_en(lz_en),
`ifdef SCAN_BLINK_EN
        .blink_mask(blink_mask),
`endif
        .sel(sel_nb), .num(num_nb), .frame_start(fs_nb)
    );

    // Expected num at offset k within a 24-cycle frame; shown holds the value per sel as nibbles.
    function automatic logic [3:0] exp_num(input int k, input logic [15:0] shown);
        if ((k % 6) < 4) return shown[4*(k/6) +: 4];
        return 4'hF;
    endfunction

    task automatic do_reset(input logic [15:0] v, input bit ld);
        rst = 1'b1;
        load = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        load = ld;
        digits = v;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic wait_fs(input bit nb, output int n);
        n = 0;
        while (((nb ? fs_nb : frame_start) !== 1'b1) && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    // Records 24 samples starting at the current (frame_start) sample, optionally pulsing load.
    task automatic capture_frame(input int la, input logic [15:0] lv,
                                 input int la2, input logic [15:0] lv2);
        cap_cyc0 = cyc;
        for (int k = 0; k < 24; k++) begin
            cap_sel[k] = sel;
            cap_num[k] = num;
            cap_fs[k]  = frame_start;
            load = 1'b0;
            if (k == la)  begin load = 1'b1; digits = lv;  end
            if (k == la2) begin load = 1'b1; digits = lv2; end
            @(posedge clk);
            #1;
        end
        load = 1'b0;
        cap_fs_end = frame_start;
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sel !== 2'd0 || num !== 4'hF || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_state sel=%0d num=%h fs=%b, required sel=0 num=f fs=0", sel, num, frame_start);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (sel !== 2'd0 || num !== 4'h0) begin
            errors++;
            $display("FAIL reset_first_show sel=%0d num=%h, required sel=0 num=0", sel, num);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (sel !== 2'd0 || num !== 4'hF) begin
            errors++;
            $display("FAIL reset_enter_blank sel=%0d num=%h, required sel=0 num=f", sel, num);
        end
        load = 1'b1;
        digits = 16'h7777;
        @(posedge clk);
        #1;
        load = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (sel !== 2'd0 || num !== 4'hF || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_blank sel=%0d num=%h fs=%b, required sel=0 num=f fs=0", sel, num, frame_start);
        end
        rst = 1'b0;
        wait_fs(1'b0, n);
        checks++;
        if (n !== 24) begin
            errors++;
            $display("FAIL reset_period edges=%0d, required 24", n);
        end
        checks++;
        if (num !== 4'h0) begin
            errors++;
            $display("FAIL reset_pending_dropped num=%h, required 0", num);
        end
    endtask

    task automatic test_load_basic();
        int n;
        do_reset(16'h1234, 1'b1);
        wait_fs(1'b0, n);
        checks++;
        if (n !== 23) begin
            errors++;
            $display("FAIL load_first_wrap edges=%0d, required 23", n);
        end
        capture_frame(-1, 16'h0, -1, 16'h0);
        for (int k = 0; k < 24; k++) begin
            checks++;
            if (cap_sel[k] !== 2'(k/6) || cap_num[k] !== exp_num(k, 16'h1234) || cap_fs[k] !== (k == 0)) begin
                errors++;
                $display("FAIL load_basic k=%0d sel=%0d num=%h fs=%b, required sel=%0d num=%h fs=%b",
                         k, cap_sel[k], cap_num[k], cap_fs[k], k/6, exp_num(k, 16'h1234), k == 0);
            end
        end
        checks++;
        if (cap_fs_end !== 1'b1) begin
            errors++;
            $display("FAIL load_period fs=%b after 24 cycles, required 1", cap_fs_end);
        end
    endtask

    task automatic test_midscan_load();
        int n;
        do_reset(16'h1234, 1'b1);
        wait_fs(1'b0, n);
        capture_frame(7, 16'h5678, -1, 16'h0);
        for (int k = 0; k < 24; k++) begin
            checks++;
            if (cap_sel[k] !== 2'(k/6) || cap_num[k] !== exp_num(k, 16'h1234)) begin
                errors++;
                $display("FAIL midscan_old k=%0d sel=%0d num=%h, required sel=%0d num=%h",
                         k, cap_sel[k], cap_num[k], k/6, exp_num(k, 16'h1234));
            end
        end
        capture_frame(-1, 16'h0, -1, 16'h0);
        for (int k = 0; k < 24; k++) begin
            checks++;
            if (cap_sel[k] !== 2'(k/6) || cap_num[k] !== exp_num(k, 16'h5678) || cap_fs[k] !== (k == 0)) begin
                errors++;
                $display("FAIL midscan_new k=%0d sel=%0d num=%h fs=%b, required sel=%0d num=%h",
                         k, cap_sel[k], cap_num[k], cap_fs[k], k/6, exp_num(k, 16'h5678));
            end
        end
    endtask

    task automatic test_double_load();
        int n;
        do_reset(16'h1234, 1'b1);
        wait_fs(1'b0, n);
        capture_frame(3, 16'h1111, 10, 16'h2222);
        for (int k = 0; k < 24; k++) begin
            checks++;
            if (cap_num[k] !== exp_num(k, 16'h1234)) begin
                errors++;
                $display("FAIL double_old k=%0d num=%h, required %h", k, cap_num[k], exp_num(k, 16'h1234));
            end
        end
        capture_frame(-1, 16'h0, -1, 16'h0);
        for (int k = 0; k < 24; k++) begin
            checks++;
            if (cap_sel[k] !== 2'(k/6) || cap_num[k] !== exp_num(k, 16'h2222)) begin
                errors++;
                $display("FAIL double_new k=%0d sel=%0d num=%h, required sel=%0d num=%h",
                         k, cap_sel[k], cap_num[k], k/6, exp_num(k, 16'h2222));
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        do_reset(16'h1234, 1'b1);
        wait_fs(1'b0, n);
        capture_frame(23, 16'h9ABC, -1, 16'h0);
        for (int k = 0; k < 24; k++) begin
            checks++;
            if (cap_num[k] !== exp_num(k, 16'h1234)) begin
                errors++;
                $display("FAIL boundary_old k=%0d num=%h, required %h", k, cap_num[k], exp_num(k, 16'h1234));
            end
        end
        capture_frame(-1, 16'h0, -1, 16'h0);
        for (int k = 0; k < 24; k++) begin
            checks++;
            if (cap_sel[k] !== 2'(k/6) || cap_num[k] !== exp_num(k, 16'h9ABC)) begin
                errors++;
                $display("FAIL boundary_new k=%0d sel=%0d num=%h, required sel=%0d num=%h",
                         k, cap_sel[k], cap_num[k], k/6, exp_num(k, 16'h9ABC));
            end
        end
    endtask

    task automatic test_leading_zero();
        int n;
        lz_en = 1'b1;
        do_reset(16'h0040, 1'b1);
        wait_fs(1'b0, n);
        capture_frame(23, 16'h0000, -1, 16'h0);
        for (int k = 0; k < 24; k++) begin
            checks++;
            if (cap_sel[k] !== 2'(k/6) || cap_num[k] !== exp_num(k, 16'hFF40)) begin
                errors++;
                $display("FAIL lz_0040 k=%0d sel=%0d num=%h, required sel=%0d num=%h",
                         k, cap_sel[k], cap_num[k], k/6, exp_num(k, 16'hFF40));
            end
        end
        capture_frame(-1, 16'h0, -1, 16'h0);
        for (int k = 0; k < 24; k++) begin
            checks++;
            if (cap_num[k] !== exp_num(k, 16'hFFF0)) begin
                errors++;
                $display("FAIL lz_0000 k=%0d num=%h, required %h", k, cap_num[k], exp_num(k, 16'hFFF0));
            end
        end
        lz_en = 1'b0;
    endtask

    task automatic test_no_blank();
        int n;
        logic [15:0] v;
        v = 16'h1234;
        do_reset(v, 1'b1);
        wait_fs(1'b1, n);
        checks++;
        if (n !== 15) begin
            errors++;
            $display("FAIL noblank_first_wrap edges=%0d, required 15", n);
        end
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (sel_nb !== 2'(k/4) || num_nb !== v[4*(k/4) +: 4] || fs_nb !== (k == 0)) begin
                errors++;
                $display("FAIL noblank k=%0d sel=%0d num=%h fs=%b, required sel=%0d num=%h",
                         k, sel_nb, num_nb, fs_nb, k/4, v[4*(k/4) +: 4]);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (fs_nb !== 1'b1) begin
            errors++;
            $display("FAIL noblank_period fs=%b after 16 cycles, required 1", fs_nb);
        end
    endtask

`ifdef SCAN_BLINK_EN
    task automatic test_blink();
        int n, s, ph;
        logic [15:0] v;
        logic [3:0]  e;
        v = 16'h1234;
        blink_mask = 4'b0011;
        do_reset(v, 1'b1);
        wait_fs(1'b0, n);
        capture_frame(-1, 16'h0, -1, 16'h0);
        for (int k = 0; k < 24; k++) begin
            s  = k / 6;
            ph = ((cap_cyc0 + k - 1) / 16) % 2;
            e  = ((k % 6) < 4 && !(ph == 1 && blink_mask[s])) ? v[4*s +: 4] : 4'hF;
            checks++;
            if (cap_num[k] !== e) begin
                errors++;
                $display("FAIL blink k=%0d num=%h, required %h", k, cap_num[k], e);
            end
        end
        blink_mask = 4'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_load_basic();
        test_midscan_load();
        test_double_load();
        test_back_to_back();
        test_leading_zero();
        test_no_blank();
`ifdef SCAN_BLINK_EN
        test_blink();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
